// File: rtl/ysyx_22040365_ifu.sv
// Instruction fetch controller: owns the PC, fetches one instruction at a time
// over a valid/ready memory port, hands it to the core and stops on ebreak.
module ysyx_22040365_ifu #(
  parameter logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000,
  parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        halt,
  output logic [63:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_retire_cnt;
  logic [31:0] r_inst;
  logic        r_kill;
  logic        r_req_valid;
  logic        r_inst_valid;
  logic        r_halt;

  logic [63:0] w_redirect_pc;
  logic [63:0] w_pc_plus4;
  logic        w_is_ebreak;

  assign w_redirect_pc = redirect_pc & ~64'd3;
  assign w_pc_plus4    = r_pc + 64'd4;
  assign w_is_ebreak   = (r_inst == EBREAK_INST);

  // The PC is only rewritten on retire or redirect, so in VALID it is the
  // address of the held instruction and can double as inst_pc.
  assign imem_req_valid = r_req_valid;
  assign imem_addr      = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign inst_pc        = r_pc;
  assign halt           = r_halt;
  assign retire_cnt     = r_retire_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC & ~64'd3;
      r_retire_cnt <= 64'd0;
      r_inst       <= 32'd0;
      r_kill       <= 1'b0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_halt       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state     <= S_REQ;
          r_req_valid <= 1'b1;
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
          end
        end

        S_REQ: begin
          if (imem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
            // The accepted request targets the old PC; its response must be dropped.
            if (redirect_valid) begin
              r_pc   <= w_redirect_pc;
              r_kill <= 1'b1;
            end
          end else if (redirect_valid) begin
            r_pc <= w_redirect_pc;
          end
        end

        S_WAIT: begin
          if (imem_resp_valid) begin
            if (redirect_valid || r_kill) begin
              if (redirect_valid) begin
                r_pc <= w_redirect_pc;
              end
              r_kill      <= 1'b0;
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_inst       <= imem_resp_data;
              r_state      <= S_VALID;
              r_inst_valid <= 1'b1;
            end
          end else if (redirect_valid) begin
            r_pc   <= w_redirect_pc;
            r_kill <= 1'b1;
          end
        end

        S_VALID: begin
          if (inst_ready) begin
            r_retire_cnt <= r_retire_cnt + 64'd1;
            r_inst_valid <= 1'b0;
            if (w_is_ebreak) begin
              r_state <= S_HALT;
              r_halt  <= 1'b1;
            end else begin
              r_pc        <= redirect_valid ? w_redirect_pc : w_pc_plus4;
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end
          end else if (redirect_valid) begin
            // Flush: the held instruction is dropped without counting.
            r_pc         <= w_redirect_pc;
            r_state      <= S_REQ;
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b1;
          end
        end

        S_HALT: begin
          r_state <= S_HALT;
        end

        default: begin
          r_state      <= S_IDLE;
          r_kill       <= 1'b0;
          r_req_valid  <= 1'b0;
          r_inst_valid <= 1'b0;
          r_halt       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ysyx_22040365_ifu.md
Name: ysyx_22040365_ifu

Overview:
- Instruction fetch controller that sequences the single-cycle core (decode, regfile, execute).
- Owns the PC and issues fetch requests to instruction memory over a valid/ready handshake.
- Presents one instruction at a time to the core, advances or redirects the PC on retire, and halts on ebreak.
- Sits between the instruction memory port and the core's `inst` input.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
- EBREAK_INST, 32'h0010_0073, encoding that triggers halt.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_addr  output  64  fetch address (= current PC, bits[1:0]=0)
- imem_resp_valid  input  1  response data valid (exactly one per accepted request, ≥1 cycle after accept)
- imem_resp_data  input  32  fetched instruction
- inst_valid  output  1  instruction held for core
- inst  output  32  instruction to core
- inst_pc  output  64  PC of `inst`
- inst_ready  input  1  core retires `inst` this cycle
- redirect_valid  input  1  PC redirect / flush
- redirect_pc  input  64  redirect target (bits[1:0] forced to 0 internally)
- halt  output  1  sticky, ebreak retired
- retire_cnt  output  64  number of retired instructions

Behaviour:
- State machine: IDLE, REQ, WAIT, VALID, HALT. Internal `kill` flag (1 bit).
- Reset, evaluated on a clock edge with rst=1, overrides everything, including mid-transaction:
  - state=IDLE, pc=RESET_PC, kill=0, retire_cnt=0, inst=0.
  - All outputs 0 except imem_addr=RESET_PC and inst_pc=RESET_PC.
  - A response arriving after reset for a pre-reset request is ignored. The memory side is also reset by rst.
- IDLE: next cycle goes to REQ unconditionally. A redirect in IDLE loads pc.
- REQ: imem_req_valid=1, imem_addr=pc.
  - imem_req_ready=1 → WAIT.
  - redirect_valid with no ready → pc<=redirect_pc, stay REQ.
  - redirect_valid with ready in the same cycle → pc<=redirect_pc, kill<=1, go WAIT.
- WAIT: imem_req_valid=0.
  - On imem_resp_valid with kill=0 → inst<=imem_resp_data, go VALID.
  - On imem_resp_valid with kill=1 → discard data, kill<=0, go REQ.
  - redirect_valid with no response → pc<=redirect_pc, kill<=1.
  - redirect_valid coinciding with a response → discard data, pc<=redirect_pc, kill<=0, go REQ.
- VALID: inst_valid=1, inst and inst_pc stable until retire.
  - inst_ready=1 → retire_cnt+=1.
  - Retiring inst == EBREAK_INST → HALT; pc unchanged.
  - Otherwise pc <= redirect_valid ? redirect_pc : pc+4 (redirect is the retiring instruction's jump/branch target), go REQ.
  - redirect_valid with inst_ready=0 → flush: drop inst, pc<=redirect_pc, go REQ, no count.
- HALT: absorbing until rst.
  - halt=1; imem_req_valid=0, inst_valid=0.
  - redirect and inst_ready ignored; retire_cnt frozen.
- Throughput: minimum 3 cycles per instruction (REQ→WAIT→VALID), with zero-wait memory: ready in REQ, response the next cycle.
- Arithmetic:
  - pc+4 wraps modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
  - retire_cnt wraps modulo 2^64.
- Outputs are registered state decodes (Moore); no combinational path from any input to imem_req_valid or inst_valid.

Test Plan:
- Reset then zero-wait memory returning addi words for 3 fetches → imem_addr 0x80000000, 0x80000004, 0x80000008; inst_valid pulses with matching inst_pc; retire_cnt=3.
- Memory holds imem_req_ready=0 for 4 cycles → imem_req_valid and imem_addr stay stable; no WAIT entry; fetch completes after ready.
- Retire with redirect_valid=1, redirect_pc=0x80000103 → next imem_addr=0x80000100; retire_cnt increments by 1.
- Redirect to 0x80000200 while in WAIT, stale response 0xDEADBEEF arrives 2 cycles later → stale data never appears on inst (inst_valid stays 0); next request at 0x80000200; that response is delivered.
- Fetch returns 0x00100073, core retires it → halt=1 next cycle and stays 1; no further requests for 20 cycles; retire_cnt frozen. Then rst=1 for 1 cycle → halt=0, imem_addr=0x80000000.
- Assert rst while in WAIT, response arrives the cycle after reset → response ignored; fetch restarts at RESET_PC with retire_cnt=0.
